// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader / console bridge.
// Holds the loader state enum, section enum, default protocol bytes and helpers.
package uart_loader_pkg;

    typedef enum logic [3:0] {
        S_SYNC, S_LEN, S_PAYLOAD, S_CSUM, S_REPLY,
        S_RUN, S_FETCH, S_SEND, S_END, S_DONE
    } state_t;

    typedef enum logic {SEC_PROG, SEC_DATA} section_t;

    localparam logic [7:0] DEF_SYNC_PROG = 8'h99;
    localparam logic [7:0] DEF_SYNC_DATA = 8'hAA;
    localparam logic [7:0] DEF_ACK_BYTE  = 8'hCC;
    localparam logic [7:0] DEF_NAK_BYTE  = 8'hEE;
    localparam logic [7:0] DEF_END_BYTE  = 8'h55;

    function automatic int bytes_per_word(input int word_w);
        return word_w / 8;
    endfunction

endpackage

// File: rtl/serial_rx.sv
// 8N1 UART receiver, WAIT_DIV clocks per bit, samples mid-bit.
// Ports: clk, rst (sync, active-high), rxd in; data/valid (1-cycle pulse) out.
module serial_rx #(
    parameter int WAIT_DIV = 43
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid
);
    localparam int CW = $clog2(WAIT_DIV + 1);

    logic [1:0]    sync;
    logic          busy;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk) begin
        valid <= 1'b0;
        if (rst) begin
            sync  <= 2'b11;
            busy  <= 1'b0;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            data  <= '0;
        end else begin
            sync <= {sync[0], rxd};
            if (!busy) begin
                if (!sync[1]) begin
                    busy <= 1'b1;
                    cnt  <= CW'(WAIT_DIV / 2);
                    idx  <= '0;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                cnt <= CW'(WAIT_DIV - 1);
                idx <= idx + 1'b1;
                // a start bit that is high again at mid-bit was a glitch
                if (idx == 4'd0 && sync[1]) begin
                    busy <= 1'b0;
                end else if (idx >= 4'd1 && idx <= 4'd8) begin
                    shreg <= {sync[1], shreg[7:1]};
                end else if (idx == 4'd9) begin
                    busy  <= 1'b0;
                    valid <= sync[1];
                    data  <= shreg;
                end
            end
        end
    end
endmodule

// File: rtl/serial_tx.sv
// 8N1 UART transmitter, WAIT_DIV clocks per bit.
// Ports: clk, rst, data/valid in (held until finish); txd, finish (1-cycle) out.
module serial_tx #(
    parameter int WAIT_DIV = 43
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       txd,
    output logic       finish
);
    localparam int CW = $clog2(WAIT_DIV + 1);

    logic          busy;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [8:0]    sh;

    always_ff @(posedge clk) begin
        finish <= 1'b0;
        if (rst) begin
            txd  <= 1'b1;
            busy <= 1'b0;
            cnt  <= '0;
            idx  <= '0;
            sh   <= '0;
        end else if (!busy) begin
            txd <= 1'b1;
            // valid is still high during the finish cycle; do not resend
            if (valid && !finish) begin
                busy <= 1'b1;
                txd  <= 1'b0;
                sh   <= {1'b1, data};
                cnt  <= CW'(WAIT_DIV - 1);
                idx  <= '0;
            end
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end else if (idx == 4'd9) begin
            busy   <= 1'b0;
            finish <= 1'b1;
        end else begin
            txd <= sh[0];
            sh  <= {1'b1, sh[8:1]};
            idx <= idx + 1'b1;
            cnt <= CW'(WAIT_DIV - 1);
        end
    end
endmodule

// File: rtl/uart_word_packer.sv
// Assembles little-endian bytes into WORD_W words, emitting a 1-cycle word_valid.
// Ports: clk, rst, clear, byte_valid/byte_data in; last (next byte completes), word_valid, word out.
module uart_word_packer
    import uart_loader_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              last,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);
    localparam int BPW = bytes_per_word(WORD_W);
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0] cnt;

    assign last = (cnt == CW'(BPW - 1));

    always_ff @(posedge clk) begin
        word_valid <= 1'b0;
        if (rst || clear) begin
            cnt  <= '0;
            word <= '0;
        end else if (byte_valid) begin
            // new byte enters at the top so the first byte ends at the LSB
            word <= (word >> 8) | (WORD_W'(byte_data) << (WORD_W - 8));
            cnt  <= last ? '0 : cnt + 1'b1;
            word_valid <= last;
        end
    end
endmodule

// File: rtl/uart_loader.sv
// UART boot loader: loads program/data images with checksum + retry, then bridges core output.
// Ports: CLK, RST, rxd/txd serial; imem_*/dmem_* write ports; core_run/core_halt; fifo_*; done.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int         WAIT_DIV  = 43,
    parameter int         WORD_W    = 32,
    parameter int         ADDR_W    = 12,
    parameter logic [7:0] SYNC_PROG = DEF_SYNC_PROG,
    parameter logic [7:0] SYNC_DATA = DEF_SYNC_DATA,
    parameter logic [7:0] ACK_BYTE  = DEF_ACK_BYTE,
    parameter logic [7:0] NAK_BYTE  = DEF_NAK_BYTE,
    parameter logic [7:0] END_BYTE  = DEF_END_BYTE
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              rxd,
    output logic              txd,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [WORD_W-1:0] dmem_wdata,
    output logic              core_run,
    input  logic              core_halt,
    input  logic              fifo_empty,
    output logic              fifo_re,
    input  logic [7:0]        fifo_rdata,
    output logic              done
);
    state_t            state;
    section_t          sec;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_finish;
    logic [7:0]        len_lo;
    logic              len_idx;
    logic [15:0]       words_left;
    logic [7:0]        csum;
    logic              csum_ok;
    logic [ADDR_W-1:0] wr_addr;
    logic              pk_last;
    logic              word_valid;
    logic [WORD_W-1:0] word;

    serial_rx #(.WAIT_DIV(WAIT_DIV)) u_rx (
        .clk(CLK), .rst(RST), .rxd(rxd),
        .data(rx_data), .valid(rx_valid)
    );

    serial_tx #(.WAIT_DIV(WAIT_DIV)) u_tx (
        .clk(CLK), .rst(RST), .data(tx_data), .valid(tx_valid),
        .txd(txd), .finish(tx_finish)
    );

    uart_word_packer #(.WORD_W(WORD_W)) u_pack (
        .clk(CLK), .rst(RST), .clear(state == S_SYNC),
        .byte_valid(rx_valid && state == S_PAYLOAD),
        .byte_data(rx_data), .last(pk_last),
        .word_valid(word_valid), .word(word)
    );

    assign imem_we    = word_valid && (sec == SEC_PROG);
    assign dmem_we    = word_valid && (sec == SEC_DATA);
    assign imem_addr  = wr_addr;
    assign dmem_addr  = wr_addr;
    assign imem_wdata = word;
    assign dmem_wdata = word;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_SYNC;
            sec        <= SEC_PROG;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            len_lo     <= '0;
            len_idx    <= 1'b0;
            words_left <= '0;
            csum       <= '0;
            csum_ok    <= 1'b0;
            wr_addr    <= '0;
            core_run   <= 1'b0;
            fifo_re    <= 1'b0;
            done       <= 1'b0;
        end else begin
            fifo_re <= 1'b0;
            if (word_valid) wr_addr <= wr_addr + 1'b1;
            unique case (state)
                S_SYNC: begin
                    wr_addr <= '0;
                    csum    <= '0;
                    len_idx <= 1'b0;
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= (sec == SEC_PROG) ? SYNC_PROG : SYNC_DATA;
                    end else if (tx_finish) begin
                        tx_valid <= 1'b0;
                        state    <= S_LEN;
                    end
                end
                S_LEN: if (rx_valid) begin
                    if (!len_idx) begin
                        len_lo  <= rx_data;
                        len_idx <= 1'b1;
                    end else begin
                        words_left <= {rx_data, len_lo};
                        state <= ({rx_data, len_lo} == 16'd0) ? S_CSUM : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: if (rx_valid) begin
                    csum <= csum + rx_data;
                    if (pk_last) begin
                        words_left <= words_left - 1'b1;
                        if (words_left == 16'd1) state <= S_CSUM;
                    end
                end
                S_CSUM: if (rx_valid) begin
                    csum_ok <= (rx_data == csum);
                    state   <= S_REPLY;
                end
                S_REPLY: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= csum_ok ? ACK_BYTE : NAK_BYTE;
                    end else if (tx_finish) begin
                        tx_valid <= 1'b0;
                        if (!csum_ok) begin
                            state <= S_SYNC;
                        end else if (sec == SEC_PROG) begin
                            sec   <= SEC_DATA;
                            state <= S_SYNC;
                        end else begin
                            core_run <= 1'b1;
                            state    <= S_RUN;
                        end
                    end
                end
                // pending output wins over halt so the FIFO drains first
                S_RUN: begin
                    if (!fifo_empty) begin
                        fifo_re <= 1'b1;
                        state   <= S_FETCH;
                    end else if (core_halt) begin
                        state <= S_END;
                    end
                end
                S_FETCH: state <= S_SEND;
                // first S_SEND cycle is the one where fifo_rdata is valid
                S_SEND: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= fifo_rdata;
                    end else if (tx_finish) begin
                        tx_valid <= 1'b0;
                        state    <= S_RUN;
                    end
                end
                S_END: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= END_BYTE;
                    end else if (tx_finish) begin
                        tx_valid <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: state <= S_DONE;
                default: state <= S_SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: table of load/run scenarios plus reset corner cases.
// Serial line, memories and output FIFO are modelled at byte/word level inside the bench.
module tb_uart_loader;
    localparam int WAIT_DIV = 8;
    localparam int WORD_W   = 32;
    localparam int ADDR_W   = 2;

    typedef logic [WORD_W-1:0] word_t;
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [WORD_W-1:0] d;
    } wr_t;
    typedef struct {
        int         pn;
        bit         pbad;
        int         dn;
        bit         dbad;
        int         nout;
        bit         fixed;
        bit         halt_early;
        logic [7:0] prog_reply;
        logic [7:0] data_reply;
    } vec_t;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              rxd = 1'b1;
    logic              core_halt = 1'b0;
    logic              fifo_empty = 1'b1;
    logic [7:0]        fifo_rdata = 8'h00;
    logic              txd;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [WORD_W-1:0] dmem_wdata;
    logic              core_run;
    logic              fifo_re;
    logic              done;

    int checks = 0;
    int errors = 0;
    int re_cnt = 0;
    logic [7:0] tx_q[$];
    logic [7:0] fq[$];
    wr_t ilog[$], dlog[$], exp_i[$], exp_d[$];

    always #5 CLK = ~CLK;

    uart_loader #(.WAIT_DIV(WAIT_DIV), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RST(RST), .rxd(rxd), .txd(txd),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .core_run(core_run), .core_halt(core_halt),
        .fifo_empty(fifo_empty), .fifo_re(fifo_re), .fifo_rdata(fifo_rdata),
        .done(done)
    );

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // serial line decoder; a byte cut short by reset is dropped
    initial begin
        forever begin
            logic [7:0] b;
            logic ok;
            int base;
            int k;
            wait (txd === 1'b1);
            wait (txd === 1'b0);
            ok = 1'b1;
            b = 8'h00;
            base = WAIT_DIV / 2 - 1;
            for (int c = 0; c <= base + 9 * WAIT_DIV; c++) begin
                @(negedge CLK);
                if (RST) begin
                    ok = 1'b0;
                    break;
                end
                if (c == base && txd !== 1'b0) ok = 1'b0;
                if (c > base && (c - base) % WAIT_DIV == 0) begin
                    k = (c - base) / WAIT_DIV;
                    if (k <= 8) b[k-1] = txd;
                    else if (txd !== 1'b1) ok = 1'b0;
                end
            end
            if (ok) tx_q.push_back(b);
        end
    end

    // memory write log and output FIFO model
    always @(negedge CLK) begin
        if (!RST) begin
            if (imem_we) ilog.push_back({imem_addr, imem_wdata});
            if (dmem_we) dlog.push_back({dmem_addr, dmem_wdata});
            if (fifo_re) begin
                re_cnt++;
                if (fq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fifo_re_empty: got pop, expected none");
                end else begin
                    fifo_rdata = fq.pop_front();
                    fifo_empty = (fq.size() == 0);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rxd = 1'b0;
        repeat (WAIT_DIV) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (WAIT_DIV) @(negedge CLK);
        end
        rxd = 1'b1;
        repeat (WAIT_DIV) @(negedge CLK);
    endtask

    task automatic send_frame(input word_t w[$], input bit bad);
        int sum;
        logic [7:0] b;
        sum = 0;
        send_byte(8'(w.size()));
        send_byte(8'(w.size() >> 8));
        foreach (w[i]) begin
            for (int k = 0; k < WORD_W / 8; k++) begin
                b = 8'(w[i] >> (8 * k));
                sum = sum + b;
                send_byte(b);
            end
        end
        send_byte(bad ? (8'(sum) ^ 8'h5A) : 8'(sum));
    endtask

    function automatic void expect_writes(input bit to_d, input word_t w[$]);
        foreach (w[i]) begin
            wr_t e;
            e.a = ADDR_W'(i % (1 << ADDR_W));
            e.d = w[i];
            if (to_d) exp_d.push_back(e);
            else exp_i.push_back(e);
        end
    endfunction

    task automatic expect_tx(input string name, input logic [7:0] exp);
        int n;
        n = 0;
        while (tx_q.size() == 0 && n < 30 * WAIT_DIV) begin
            @(negedge CLK);
            n++;
        end
        if (tx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no byte (timeout), expected %02h", name, exp);
        end else begin
            check(name, tx_q.pop_front(), exp);
        end
    endtask

    task automatic compare_log(input string name, input wr_t got[$], input wr_t exp[$]);
        check({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        core_halt = 1'b0;
        rxd = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_txd", txd, 1);
        check("rst_we", {imem_we, dmem_we}, 0);
        check("rst_addr", {imem_addr, dmem_addr}, 0);
        check("rst_wdata", {imem_wdata, dmem_wdata}, 0);
        check("rst_run_re_done", {core_run, fifo_re, done}, 0);
        tx_q.delete();
        ilog.delete();
        dlog.delete();
        exp_i.delete();
        exp_d.delete();
        fq.delete();
        fifo_empty = 1'b1;
        re_cnt = 0;
        RST = 1'b0;
    endtask

    task automatic run_vec(input vec_t t);
        word_t pw[$], dw[$];
        logic [7:0] ob[$];
        do_reset();
        if (t.fixed) begin
            pw.push_back(32'h0000_0013);
            pw.push_back(32'h0010_0093);
            ob.push_back(8'h48);
            ob.push_back(8'h69);
        end else begin
            for (int i = 0; i < t.pn; i++) pw.push_back(word_t'($urandom));
            for (int i = 0; i < t.nout; i++) ob.push_back(8'($urandom));
        end
        for (int i = 0; i < t.dn; i++) dw.push_back(word_t'($urandom));
        if (t.halt_early) core_halt = 1'b1;

        expect_tx("sync_prog", 8'h99);
        send_frame(pw, t.pbad);
        expect_writes(0, pw);
        expect_tx("prog_reply", t.prog_reply);
        if (t.pbad) begin
            expect_tx("prog_resync", 8'h99);
            check("no_dmem_on_nak", dlog.size(), 0);
            send_frame(pw, 1'b0);
            expect_writes(0, pw);
            expect_tx("prog_ack", 8'hCC);
        end
        expect_tx("sync_data", 8'hAA);
        check("run_low_prerun", core_run, 0);
        check("done_low_prerun", done, 0);

        send_frame(dw, t.dbad);
        expect_writes(1, dw);
        expect_tx("data_reply", t.data_reply);
        if (t.dbad) begin
            expect_tx("data_resync", 8'hAA);
            send_frame(dw, 1'b0);
            expect_writes(1, dw);
            expect_tx("data_ack", 8'hCC);
        end
        repeat (2 * WAIT_DIV) @(negedge CLK);
        check("core_run_high", core_run, 1);

        if (!t.halt_early) begin
            foreach (ob[i]) fq.push_back(ob[i]);
            fifo_empty = (fq.size() == 0);
            core_halt = 1'b1;
        end
        foreach (ob[i]) expect_tx($sformatf("out_byte[%0d]", i), ob[i]);
        expect_tx("end_byte", 8'h55);
        repeat (2 * WAIT_DIV) @(negedge CLK);
        check("done_high", done, 1);
        check("run_in_done", core_run, 1);
        check("fifo_re_count", re_cnt, ob.size());
        check("tx_extra", tx_q.size(), 0);
        compare_log("imem", ilog, exp_i);
        compare_log("dmem", dlog, exp_d);
    endtask

    initial begin
        vec_t vt[5];
        word_t one[$];
        vt[0] = '{2, 1'b1, 0, 1'b0, 2, 1'b1, 1'b0, 8'hEE, 8'hCC};
        vt[1] = '{5, 1'b0, 3, 1'b1, 3, 1'b0, 1'b0, 8'hCC, 8'hEE};
        vt[2] = '{1, 1'b0, 6, 1'b0, 0, 1'b0, 1'b1, 8'hCC, 8'hCC};
        vt[3] = '{0, 1'b0, 2, 1'b0, 1, 1'b0, 1'b0, 8'hCC, 8'hCC};
        vt[4] = '{4, 1'b1, 1, 1'b0, 4, 1'b0, 1'b0, 8'hEE, 8'hCC};

        for (int v = 0; v < 5; v++) run_vec(vt[v]);

        // reset while running: run/done fall at the sampling edge
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("rst_run_drop", core_run, 0);
        check("rst_done_drop", done, 0);
        check("rst_txd_idle", txd, 1);

        // reset in the middle of a payload word
        do_reset();
        expect_tx("sync_mid", 8'h99);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        check("no_we_midword", ilog.size(), 0);
        do_reset();
        expect_tx("sync_after_rst", 8'h99);
        repeat (4 * WAIT_DIV) @(negedge CLK);
        check("no_we_after_rst", ilog.size(), 0);
        check("run_low_after_rst", core_run, 0);
        one.push_back(32'hCAFE_F00D);
        send_frame(one, 1'b0);
        expect_writes(0, one);
        expect_tx("ack_after_rst", 8'hCC);
        expect_tx("sync_data_after_rst", 8'hAA);
        compare_log("imem_after_rst", ilog, exp_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_loader.md
# uart_loader

UART boot loader and console bridge for the RISC-V core. After reset it handshakes with the host, receives a length-prefixed, checksummed program image into instruction memory and a data image into data memory, then releases the core. While the core runs, it streams the core's output FIFO back over the serial line and sends an end marker once the core halts. It generalises the fixed two-phase loader to a parametrised word width, address depth, explicit image lengths, checksum with retry, and continuous output streaming.

## Interface
Parameters:
- WAIT_DIV, 43: baud divider passed to serial_rx/serial_tx.
- WORD_W, 32: memory word width; multiple of 8, 8..64.
- ADDR_W, 12: word-address width of each memory; depth 2^ADDR_W.
- SYNC_PROG, 8'h99: byte that requests the program image.
- SYNC_DATA, 8'hAA: byte that requests the data image.
- ACK_BYTE / NAK_BYTE / END_BYTE, 8'hCC / 8'hEE / 8'h55.

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- rxd  in  1  serial input.
- txd  out  1  serial output; idles high.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  instruction word address.
- imem_wdata  out  WORD_W  instruction word.
- dmem_we / dmem_addr / dmem_wdata  out  1 / ADDR_W / WORD_W  data-memory write port, same rules as imem.
- core_run  out  1  high once both images are loaded; holds the core in reset while low.
- core_halt  in  1  core has finished; sampled only while core_run=1.
- fifo_empty  in  1  output FIFO empty.
- fifo_re  out  1  one-cycle FIFO pop.
- fifo_rdata  in  8  FIFO head byte; valid the cycle after fifo_re.
- done  out  1  END_BYTE transmitted; sticky until reset.

## Operation
- Section frame on rxd: LEN_LO, LEN_HI (16-bit word count N), then N·WORD_W/8 payload bytes, little-endian within each word, then CSUM, the 8-bit sum of payload bytes mod 256.
- States:
  - S_SYNC: transmit SYNC_PROG for section 0 or SYNC_DATA for section 1 -> S_LEN.
  - S_LEN: 2 bytes -> S_PAYLOAD, or S_CSUM if N=0.
  - S_PAYLOAD: N words -> S_CSUM.
  - S_CSUM: 1 byte -> S_REPLY.
  - S_REPLY: transmit ACK_BYTE on match, NAK_BYTE on mismatch.
    - NAK -> S_SYNC, same section; the write address restarts at 0.
    - ACK, section 0 -> S_SYNC, section 1.
    - ACK, section 1 -> S_RUN.
  - S_RUN: core_run=1.
    - tx idle and !fifo_empty -> S_FETCH.
    - fifo_empty and core_halt -> S_END.
  - S_FETCH: pop the FIFO (fifo_re), latch the byte -> S_SEND.
  - S_SEND: transmit the latched byte -> S_RUN.
  - S_END: transmit END_BYTE -> S_DONE.
  - S_DONE: terminal; core_run stays 1 and done=1.
- Transmit: hold the byte and tx-valid to serial_tx until its finish pulse; the state advances on the finish pulse.
- Bytes received outside S_LEN/S_PAYLOAD/S_CSUM are discarded.
- Write address: starts at 0 per attempt, increments per word, and wraps mod 2^ADDR_W if N > 2^ADDR_W (later words overwrite earlier ones; no error).
- Checksum accumulator: 8-bit, cleared on entry to S_LEN, adds payload bytes only.
- Data memory is never written during section 0, and instruction memory never during section 1.

## Timing
- Reset values: txd=1, imem_we=dmem_we=0, both addresses 0, wdata 0, core_run=0, fifo_re=0, done=0; state S_SYNC, section 0, packer cleared.
- Reset mid-operation: any partial word is dropped, an in-flight tx byte is abandoned (txd returns high), core_run drops in the same cycle, and the loader restarts from SYNC_PROG.
- Write latency: *_we pulses for exactly 1 cycle, the cycle after the rx-valid of the word's last byte. The address is applied in that cycle and increments after it.
- fifo_re: at most one pulse per transmitted byte; never asserted while fifo_empty=1.
- fifo_rdata is captured the cycle after fifo_re.
- FIFO non-empty and core_halt in the same cycle: the byte is drained first, and END_BYTE goes out only once the FIFO is empty.
- core_halt before core_run=1 is ignored.

## Structure
- uart_loader_pkg holds:
  - the state enum;
  - the section enum (SEC_PROG, SEC_DATA);
  - default byte constants;
  - a BYTES_PER_WORD = WORD_W/8 helper function.
- Sub-module uart_word_packer(WORD_W):
  - shifts in rx bytes LSB-first;
  - emits a word_valid pulse with the word;
  - has a synchronous clear.
- serial_rx and serial_tx are instantiated unchanged with WAIT_DIV.

## Test plan
- WORD_W=32: program N=2, words 0x00000013 and 0x00100093, correct CSUM=0xB6.
  -> imem writes addr0=0x00000013 and addr1=0x00100093, then ACK 0xCC and SYNC 0xAA on txd.
- Corrupt CSUM on the program image.
  -> NAK 0xEE, SYNC 0x99 resent, no dmem write; a correct resend writes from addr 0 again.
- Data section N=0, CSUM=0x00.
  -> no dmem_we, ACK 0xCC, core_run rises.
- After core_run, push bytes 0x48 and 0x69 into the FIFO, then raise core_halt.
  -> txd sends 0x48, 0x69, 0x55; done=1; two fifo_re pulses total.
- ADDR_W=2, program N=5.
  -> the fifth word is written to addr 0; ACK 0xCC.
- Assert RST during S_PAYLOAD mid-word.
  -> no further imem_we, core_run=0, next txd byte is 0x99.
